// File: rtl/morse_letter_tx_if.sv
// Handshake bundle for the Morse letter transmitter: request side drives
// start/letter/repeat_mode, the transmitter returns out/busy/done/error.
interface morse_letter_tx_if;
    logic       start;
    logic [4:0] letter;
    logic       repeat_mode;
    logic       out;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, letter, repeat_mode,
        input  out, busy, done, error
    );

    modport slave (
        input  start, letter, repeat_mode,
        output out, busy, done, error
    );
endinterface

// File: rtl/morse_letter_tx.sv
// Morse letter transmitter: looks up an A-Z letter in the ITU table and keys a
// registered on/off output with unit timing, optionally repeating as a beacon.
module morse_letter_tx #(
    parameter int UNIT_CYCLES      = 25000000,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    morse_letter_tx_if.slave bus
);
    localparam int CW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int MAXU = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
    localparam int RW   = $clog2(MAXU + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [RW-1:0] rem, rem_nx;
    logic [1:0]    idx, idx_nx;
    logic [1:0]    last, last_nx;
    logic [3:0]    code, code_nx;
    logic          out_nx, busy_nx, done_nx, error_nx;
    logic          tick;

    // Returns {element count - 1, elements}; bit 0 is sent first, 1 = dash.
    function automatic logic [5:0] lookup(input logic [4:0] l);
        case (l)
            5'd0:    lookup = {2'd1, 4'b0010};
            5'd1:    lookup = {2'd3, 4'b0001};
            5'd2:    lookup = {2'd3, 4'b0101};
            5'd3:    lookup = {2'd2, 4'b0001};
            5'd4:    lookup = {2'd0, 4'b0000};
            5'd5:    lookup = {2'd3, 4'b0100};
            5'd6:    lookup = {2'd2, 4'b0011};
            5'd7:    lookup = {2'd3, 4'b0000};
            5'd8:    lookup = {2'd1, 4'b0000};
            5'd9:    lookup = {2'd3, 4'b1110};
            5'd10:   lookup = {2'd2, 4'b0101};
            5'd11:   lookup = {2'd3, 4'b0010};
            5'd12:   lookup = {2'd1, 4'b0011};
            5'd13:   lookup = {2'd1, 4'b0001};
            5'd14:   lookup = {2'd2, 4'b0111};
            5'd15:   lookup = {2'd3, 4'b0110};
            5'd16:   lookup = {2'd3, 4'b1011};
            5'd17:   lookup = {2'd2, 4'b0010};
            5'd18:   lookup = {2'd2, 4'b0000};
            5'd19:   lookup = {2'd0, 4'b0001};
            5'd20:   lookup = {2'd2, 4'b0100};
            5'd21:   lookup = {2'd3, 4'b1000};
            5'd22:   lookup = {2'd2, 4'b0110};
            5'd23:   lookup = {2'd3, 4'b1001};
            5'd24:   lookup = {2'd3, 4'b1101};
            5'd25:   lookup = {2'd3, 4'b0011};
            default: lookup = 6'd0;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            idx       <= '0;
            last      <= '0;
            code      <= '0;
            bus.out   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rem       <= rem_nx;
            idx       <= idx_nx;
            last      <= last_nx;
            code      <= code_nx;
            bus.out   <= out_nx;
            bus.busy  <= busy_nx;
            bus.done  <= done_nx;
            bus.error <= error_nx;
        end
    end

    // The unit counter wraps on every tick and states only change on a tick
    // (or from IDLE, where it is held at zero), so each state starts at count 0.
    always_comb begin
        state_nx = state;
        cnt_nx   = tick ? '0 : cnt + CW'(1);
        rem_nx   = rem;
        idx_nx   = idx;
        last_nx  = last;
        code_nx  = code;
        done_nx  = 1'b0;
        error_nx = 1'b0;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (bus.start) begin
                    if (bus.letter <= 5'd25) begin
                        {last_nx, code_nx} = lookup(bus.letter);
                        idx_nx   = 2'd0;
                        rem_nx   = code_nx[0] ? RW'(DASH_UNITS) : RW'(1);
                        state_nx = MARK;
                    end else begin
                        error_nx = 1'b1;
                    end
                end
            end
            MARK: begin
                if (tick) begin
                    if (rem == RW'(1)) begin
                        if (idx != last) begin
                            rem_nx   = RW'(1);
                            state_nx = GAP;
                        end else if (bus.repeat_mode) begin
                            rem_nx   = RW'(LETTER_GAP_UNITS);
                            state_nx = LGAP;
                        end else begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        rem_nx = rem - RW'(1);
                    end
                end
            end
            GAP, LGAP: begin
                if (tick) begin
                    if (rem == RW'(1)) begin
                        idx_nx   = (state == GAP) ? idx + 2'd1 : 2'd0;
                        rem_nx   = code[idx_nx] ? RW'(DASH_UNITS) : RW'(1);
                        state_nx = MARK;
                    end else begin
                        rem_nx = rem - RW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        out_nx  = (state_nx == MARK);
        busy_nx = (state_nx != IDLE);
    end
endmodule

// File: tb/tb_morse_letter_tx.sv
// Randomised bench for morse_letter_tx: expected waveforms are built from the
// dot/dash text of each letter and compared cycle by cycle.
module tb_morse_letter_tx;
    localparam int U  = 4;
    localparam int DU = 3;
    localparam int LG = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   wave[$];
    int   final_start;
    int   order[26];

    string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                             "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                             "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                             "-.--", "--.."};

    always #5 clk = ~clk;

    morse_letter_tx_if bus ();

    morse_letter_tx #(
        .UNIT_CYCLES(U),
        .DASH_UNITS(DU),
        .LETTER_GAP_UNITS(LG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic checkOutput(input string tag, input int obs, input int expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    // Expected out, one entry per cycle, for a letter sent reps times.
    function automatic void build_wave(input int l, input int reps);
        string s;
        s = morse_tab[l];
        wave.delete();
        final_start = 0;
        for (int r = 0; r < reps; r++) begin
            if (r > 0)
                for (int k = 0; k < LG * U; k++) wave.push_back(0);
            final_start = wave.size();
            for (int e = 0; e < s.len(); e++) begin
                int units;
                if (e > 0)
                    for (int k = 0; k < U; k++) wave.push_back(0);
                units = (s.getc(e) == "-") ? DU : 1;
                for (int k = 0; k < units * U; k++) wave.push_back(1);
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic applyStimulus(input int l, input int reps, input bit chatter);
        build_wave(l, reps);
        bus.letter      = 5'(l);
        bus.repeat_mode = (reps > 1);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < wave.size(); i++) begin
            checkOutput($sformatf("out[%0d]", l), int'(bus.out), wave[i]);
            checkOutput("busy", int'(bus.busy), 1);
            checkOutput("done_early", int'(bus.done), 0);
            checkOutput("error_busy", int'(bus.error), 0);
            if (i == final_start) bus.repeat_mode = 1'b0;
            if (chatter) begin
                bus.start  = ($urandom_range(0, 2) == 0);
                bus.letter = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("done_pulse", int'(bus.done), 1);
        checkOutput("busy_end", int'(bus.busy), 0);
        checkOutput("out_end", int'(bus.out), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_done", int'(bus.done), 0);
            checkOutput("idle_busy", int'(bus.busy), 0);
            checkOutput("idle_out", int'(bus.out), 0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.letter      = 5'd0;
        bus.repeat_mode = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out", int'(bus.out), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_error", int'(bus.error), 0);
        reset = 1'b0;
        idle_cycles(2);

        applyStimulus(4, 1, 0);
        idle_cycles(1);
        applyStimulus(0, 1, 0);
        idle_cycles(1);

        // Invalid letter: single error pulse, then a valid letter goes through.
        bus.letter = 5'($urandom_range(26, 31));
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("error_pulse", int'(bus.error), 1);
        checkOutput("error_busy0", int'(bus.busy), 0);
        checkOutput("error_out0", int'(bus.out), 0);
        applyStimulus(19, 1, 0);
        idle_cycles(1);

        applyStimulus(19, 3, 1);
        idle_cycles(1);
        applyStimulus($urandom_range(0, 25), 2, 1);
        idle_cycles(1);

        // Reset mid-dash of Q, asserted together with a new start.
        build_wave(16, 1);
        bus.letter = 5'd16;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("q_out", int'(bus.out), wave[i]);
            @(negedge clk);
        end
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out", int'(bus.out), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("postrst_busy", int'(bus.busy), 0);
        checkOutput("postrst_done", int'(bus.done), 0);
        applyStimulus(4, 1, 0);

        // All letters in shuffled order, sometimes back to back.
        for (int i = 0; i < 26; i++) order[i] = i;
        for (int i = 25; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 26; i++) begin
            applyStimulus(order[i], 1, 1);
            idle_cycles($urandom_range(0, 1));
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom_range(0, 25), $urandom_range(1, 2), 1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
